sa_result_drain: RTL and testbench
==================================

SA_RESULT_DRAIN -- requirements
Module: sa_result_drain

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 8, width of one C element.
REQ-002 The block SHALL have parameter N, default 16, array dimension (N x N results).
REQ-003 The block SHALL have parameter LATENCY, default 3*N-1, cycles from start to valid C.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  single-cycle pulse; first skewed A/B column entered the array this cycle.
REQ-007 c_in  input  BIT_WIDTH*N*N  flattened array result; element (r,c) at bits [(r*N+c)*BIT_WIDTH +: BIT_WIDTH].
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_valid  output  1  out_data holds a valid result row.
REQ-010 out_data  output  BIT_WIDTH*N  one result row; lane c = element (row,c) at bits [c*BIT_WIDTH +: BIT_WIDTH].
REQ-011 out_row  output  clog2(N) (min 1)  index of row on out_data.
REQ-012 out_last  output  1  high with out_valid when out_row = N-1.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse after the last row handshake.
REQ-015 start_err  output  1  sticky; start seen while busy.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, CAPTURE, DRAIN.
REQ-017 IDLE -> WAIT on start=1; wait counter loaded with 1 in that cycle.
REQ-018 WAIT: counter increments each cycle; transition to CAPTURE in the cycle after counter reaches LATENCY.
REQ-019 CAPTURE: full c_in snapshot into internal N*N buffer in one cycle; row index cleared to 0; -> DRAIN next cycle.
REQ-020 DRAIN: out_valid=1; out_data = buffer row[out_row]; further c_in changes SHALL NOT affect output.
REQ-021 Handshake: transfer when out_valid & out_ready; out_data/out_row held stable while out_valid & !out_ready.
REQ-022 On transfer with out_row < N-1: out_row increments next cycle, out_valid stays 1 (one row per cycle at full throughput).
REQ-023 On transfer with out_row = N-1: -> IDLE, out_valid=0 and done=1 next cycle.
REQ-024 Total start-to-first-valid latency SHALL be LATENCY+2 cycles.
REQ-025 start while busy SHALL be ignored for sequencing and SHALL set start_err until reset.
REQ-026 start coincident with the done cycle (state IDLE) SHALL be accepted normally.
REQ-027 No arithmetic on data; elements passed bit-exact, no truncation or sign handling.

Reset
REQ-028 reset SHALL win over all other inputs in the same cycle, including mid-WAIT and mid-DRAIN.
REQ-029 Reset values: state IDLE, out_valid 0, out_data 0, out_row 0, out_last 0, busy 0, done 0, start_err 0, counters 0.
REQ-030 Buffer contents need not be cleared; they SHALL NOT be visible until a new CAPTURE.

Configuration
REQ-031 Macro SA_DRAIN_CLEAR_EN: when defined, add output sa_clear (1 bit), asserted exactly in the CAPTURE cycle, to clear array accumulators for the next matrix.
REQ-032 Without SA_DRAIN_CLEAR_EN the sa_clear port SHALL not exist; all other behaviour identical.

Verification (N=4, BIT_WIDTH=8, LATENCY=11)
REQ-033 Reset, start at cycle 0, c_in element (r,c)=r*4+c, out_ready=1 -> out_valid first at cycle 13; rows 0..3 on cycles 13..16, row 1 data = 0x07060504; out_last at cycle 16; done at 17.
REQ-034 Same, out_ready toggling 1,0,1,0 from cycle 13 -> each row held during ready=0 cycles; rows arrive in order with no duplicates; done after 4th transfer.
REQ-035 Change c_in to all 0xFF at cycle 14 -> drained rows still equal captured values.
REQ-036 Second start at cycle 5 -> start_err=1 and stays 1; drain timing unchanged from REQ-033.
REQ-037 reset at cycle 14 (mid-DRAIN) -> cycle 15 out_valid=0, busy=0; new start drains correctly.
REQ-038 With SA_DRAIN_CLEAR_EN, start at cycle 0 -> sa_clear=1 only in cycle 12; without macro, build has no sa_clear port.

Source files
------------

// File: rtl/sa_result_drain.sv
// sa_result_drain: waits LATENCY cycles after start, snapshots the N x N
// systolic-array result, then drains it one row per valid/ready handshake.
// Ports: clk, reset (sync, active-high), start, c_in (flattened N*N results),
//   out_ready/out_valid/out_data/out_row/out_last (row stream),
//   busy, done (pulse after last row), start_err (sticky start-while-busy).
// Optional macro SA_DRAIN_CLEAR_EN adds output sa_clear, high in the
//   CAPTURE cycle so the array accumulators can be cleared for the next matrix.
module sa_result_drain #(
   parameter int BIT_WIDTH = 8,
   parameter int N         = 16,
   parameter int LATENCY   = 3*N-1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [BIT_WIDTH*N*N-1:0]       c_in,
   input  logic                           out_ready,
   output logic                           out_valid,
   output logic [BIT_WIDTH*N-1:0]         out_data,
   output logic [((N>1)?$clog2(N):1)-1:0] out_row,
   output logic                           out_last,
   output logic                           busy,
   output logic                           done,
`ifdef SA_DRAIN_CLEAR_EN
   output logic                           sa_clear,
`endif
   output logic                           start_err
);

   localparam int RW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(LATENCY + 1) + 1;
   localparam int RB = BIT_WIDTH * N;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);
   localparam logic [CW-1:0] LAT_CNT  = CW'(LATENCY);

   logic [1:0]               state;
   logic [CW-1:0]            cnt;
   logic [BIT_WIDTH*N*N-1:0] snap_q;
   logic [RB-1:0]            row_sel;
   logic                     xfer;

   assign busy     = (state != S_IDLE);
   assign xfer     = out_valid & out_ready;
   assign out_last = out_valid & (out_row == LAST_ROW);

   // Gating with out_valid keeps stale buffer contents invisible
   // after reset and between matrices.
   always_comb begin
      row_sel  = snap_q[out_row*RB +: RB];
      out_data = out_valid ? row_sel : '0;
   end

`ifdef SA_DRAIN_CLEAR_EN
   assign sa_clear = (state == S_CAPTURE);
`endif

   // Snapshot buffer needs no reset.
   always_ff @(posedge clk) begin
      if (state == S_CAPTURE) begin
         snap_q <= c_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_row   <= '0;
         done      <= 1'b0;
         start_err <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start && busy) begin
            start_err <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_WAIT;
                  cnt   <= CW'(1);
               end
            end
            S_WAIT: begin
               if (cnt == LAT_CNT) begin
                  state <= S_CAPTURE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_CAPTURE: begin
               state     <= S_DRAIN;
               out_row   <= '0;
               out_valid <= 1'b1;
            end
            S_DRAIN: begin
               if (xfer) begin
                  if (out_row == LAST_ROW) begin
                     state     <= S_IDLE;
                     out_valid <= 1'b0;
                     out_row   <= '0;
                     done      <= 1'b1;
                  end else begin
                     out_row <= out_row + RW'(1);
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sa_result_drain.sv
// tb_sa_result_drain: randomized and directed scenarios for sa_result_drain
// with N=4, BIT_WIDTH=8, LATENCY=11, checked against a timeline model.
module tb_sa_result_drain;

   localparam int BW  = 8;
   localparam int N   = 4;
   localparam int LAT = 11;
   localparam int W   = BW * N * N;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  c_in = '0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [BW*N-1:0] out_data;
   logic [1:0]    out_row;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          start_err;
`ifdef SA_DRAIN_CLEAR_EN
   logic          sa_clear;
`endif

   int checks = 0;
   int failures = 0;

   // Observed event cycles from the latest scenario.
   int obs_first_valid;
   int obs_last_cyc;
   int obs_done_cyc;
   logic [BW*N-1:0] obs_row1;

   always #5 clk = ~clk;

   sa_result_drain #(.BIT_WIDTH(BW), .N(N), .LATENCY(LAT)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .c_in(c_in),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_row(out_row),
      .out_last(out_last),
      .busy(busy),
      .done(done),
`ifdef SA_DRAIN_CLEAR_EN
      .sa_clear(sa_clear),
`endif
      .start_err(start_err)
   );

   function automatic logic [W-1:0] pattern_cin();
      logic [W-1:0] v;
      v = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            v[(r*N+c)*BW +: BW] = BW'(r*N + c);
      return v;
   endfunction

   function automatic logic [W-1:0] random_cin();
      logic [W-1:0] v;
      for (int i = 0; i < W/32; i++)
         v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      out_ready = 1'b1;
      c_in = random_cin();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out_data, out_row, out_last, busy, done, start_err}
          !== '0) begin
         failures++;
         $display("FAIL reset_values got v=%0b d=%h r=%0d l=%0b b=%0b dn=%0b e=%0b want all 0",
                  out_valid, out_data, out_row, out_last, busy, done, start_err);
      end
      reset = 1'b0;
      start = 1'b0;
   endtask

   // rmode: 0 ready=1, 1 ready toggles 1,0,.. from cycle 13, 2 random.
   // cmode: 0 pattern, 1 pattern then 0xFF from 14, 2 random every cycle.
   // s2: cycle of an extra start pulse (-1 none); rst_at: reset cycle (-1).
   task automatic run_scenario(string nm, int rmode, int cmode,
                               int s2, int rst_at, int ncyc);
      bit           m_busy = 0;
      int           m_t0 = 0;
      int           m_sent = 0;
      bit           m_done = 0;
      bit           m_err = 0;
      logic [W-1:0] m_cap = '0;
      bit           e_valid;
      logic [BW*N-1:0] e_data;
      bit           rd;
      obs_first_valid = -1;
      obs_last_cyc = -1;
      obs_done_cyc = -1;
      obs_row1 = '0;
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         e_valid = m_busy && (cyc >= m_t0 + LAT + 2) && (m_sent < N);
         e_data = e_valid ? m_cap[m_sent*BW*N +: BW*N] : '0;
         checks++;
         if (out_valid !== e_valid || out_data !== e_data ||
             (e_valid && out_row !== 2'(m_sent))) begin
            failures++;
            $display("FAIL %s data c%0d got v=%0b r=%0d d=%h want v=%0b r=%0d d=%h",
                     nm, cyc, out_valid, out_row, out_data, e_valid, m_sent, e_data);
         end
         checks++;
         if (out_last !== (e_valid && m_sent == N-1) || busy !== m_busy ||
             done !== m_done || start_err !== m_err) begin
            failures++;
            $display("FAIL %s ctl c%0d got l=%0b b=%0b dn=%0b e=%0b want l=%0b b=%0b dn=%0b e=%0b",
                     nm, cyc, out_last, busy, done, start_err,
                     e_valid && m_sent == N-1, m_busy, m_done, m_err);
         end
`ifdef SA_DRAIN_CLEAR_EN
         checks++;
         if (sa_clear !== (m_busy && cyc == m_t0 + LAT + 1)) begin
            failures++;
            $display("FAIL %s sa_clear c%0d got %0b want %0b", nm, cyc,
                     sa_clear, m_busy && cyc == m_t0 + LAT + 1);
         end
`endif
         if (out_valid === 1'b1 && obs_first_valid < 0) obs_first_valid = cyc;
         if (out_last === 1'b1) obs_last_cyc = cyc;
         if (done === 1'b1 && obs_done_cyc < 0) obs_done_cyc = cyc;
         if (out_valid === 1'b1 && out_row === 2'd1) obs_row1 = out_data;

         start = (cyc == 0) || (cyc == s2);
         reset = (cyc == rst_at);
         case (rmode)
            0: rd = 1'b1;
            1: rd = (cyc < LAT + 2) || (((cyc - LAT - 2) % 2) == 0);
            default: rd = 1'($urandom_range(0, 1));
         endcase
         out_ready = rd;
         case (cmode)
            0: c_in = pattern_cin();
            1: c_in = (cyc >= 14) ? {W{1'b1}} : pattern_cin();
            default: c_in = random_cin();
         endcase

         if (reset) begin
            m_busy = 0; m_sent = 0; m_done = 0; m_err = 0;
         end else begin
            m_done = 0;
            if (start && m_busy) m_err = 1;
            if (m_busy) begin
               if (cyc == m_t0 + LAT + 1) m_cap = c_in;
               if (e_valid && rd) begin
                  m_sent++;
                  if (m_sent == N) begin
                     m_busy = 0;
                     m_done = 1;
                  end
               end
            end else if (start) begin
               m_busy = 1;
               m_t0 = cyc;
               m_sent = 0;
            end
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_basic();
      run_scenario("basic", 0, 0, -1, -1, 24);
      checks++;
      if (obs_first_valid != 13 || obs_last_cyc != 16 || obs_done_cyc != 17) begin
         failures++;
         $display("FAIL basic_timing got first=%0d last=%0d done=%0d want 13 16 17",
                  obs_first_valid, obs_last_cyc, obs_done_cyc);
      end
      checks++;
      if (obs_row1 !== 32'h07060504) begin
         failures++;
         $display("FAIL basic_row1 got %h want 07060504", obs_row1);
      end
   endtask

   task automatic test_backpressure();
      run_scenario("toggle", 1, 0, -1, -1, 26);
      checks++;
      if (obs_first_valid != 13 || obs_done_cyc != 20) begin
         failures++;
         $display("FAIL toggle_timing got first=%0d done=%0d want 13 20",
                  obs_first_valid, obs_done_cyc);
      end
   endtask

   task automatic test_hold_capture();
      run_scenario("ff_after", 0, 1, -1, -1, 22);
      checks++;
      if (obs_row1 !== 32'h07060504) begin
         failures++;
         $display("FAIL ff_row1 got %h want 07060504", obs_row1);
      end
   endtask

   task automatic test_start_err();
      run_scenario("start_err", 0, 0, 5, -1, 24);
      checks++;
      if (obs_first_valid != 13 || obs_done_cyc != 17 || start_err !== 1'b1) begin
         failures++;
         $display("FAIL start_err_timing got first=%0d done=%0d err=%0b want 13 17 1",
                  obs_first_valid, obs_done_cyc, start_err);
      end
   endtask

   task automatic test_reset_mid_drain();
      run_scenario("mid_reset", 0, 2, -1, 14, 20);
      checks++;
      if (obs_done_cyc != -1) begin
         failures++;
         $display("FAIL mid_reset_done got %0d want none", obs_done_cyc);
      end
      run_scenario("after_reset", 2, 2, -1, -1, 50);
      checks++;
      if (obs_done_cyc < 17) begin
         failures++;
         $display("FAIL after_reset_done got %0d want >=17", obs_done_cyc);
      end
   endtask

   task automatic test_back_to_back();
      run_scenario("b2b", 0, 2, 17, -1, 40);
      checks++;
      if (start_err !== 1'b0) begin
         failures++;
         $display("FAIL b2b_err got %0b want 0", start_err);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 4; k++) begin
         test_reset();
         run_scenario("random", 2, 2, int'($urandom_range(3, 20)), -1, 60);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reset();
      test_backpressure();
      test_reset();
      test_hold_capture();
      test_reset();
      test_start_err();
      test_reset();
      test_reset_mid_drain();
      test_reset();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
